// File: rtl/debug_ctrl_if.sv
// debug_ctrl_if: UART byte handshake between debug_ctrl (master) and the UART (slave)
interface debug_ctrl_if;
  logic [7:0] rx_dato_out;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] tx_dato_in;
  logic       tx_start;
  modport master (input rx_dato_out, rx_done, tx_done, output tx_dato_in, tx_start);
  modport slave  (output rx_dato_out, rx_done, tx_done, input tx_dato_in, tx_start);
endinterface

// File: rtl/debug_ctrl.sv
// debug_ctrl: UART-driven run/step controller that dumps debug_signal LSB-first after each run.
// Define DEBUG_CTRL_ACK_EN to prefix dumps with 8'hA5 and answer unknown commands with "?".
module debug_ctrl #(
  parameter int         DATA_W   = 322,
  parameter int         PC_W     = 10,
  parameter int         PC_STOP  = 62,
  parameter logic [7:0] CMD_CONT = 8'h63,
  parameter logic [7:0] CMD_STEP = 8'h73
) (
  input  logic              clk,
  input  logic              reset,
  debug_ctrl_if.master      uart,
  input  logic [DATA_W-1:0] debug_signal,
  output logic              enable,
  output logic              busy
);
  localparam int NUM_BYTES = (DATA_W + 7) / 8;
  localparam int SNAP_W    = NUM_BYTES * 8;
`ifdef DEBUG_CTRL_ACK_EN
  localparam int NSEND = NUM_BYTES + 1;
`else
  localparam int NSEND = NUM_BYTES;
`endif
  localparam int BUF_W = NSEND * 8;
  localparam int CNT_W = $clog2(NSEND + 1);
  typedef enum logic [2:0] {IDLE, CONT, STEP1, STEP2, LOAD, SEND, WAIT} state_t;
  state_t             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SNAP_W-1:0]  snap;
  logic [PC_W-1:0]    pc;
  assign snap = SNAP_W'(debug_signal);
  assign pc   = debug_signal[DATA_W-1 -: PC_W];
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (uart.rx_done)
          state_d = uart.rx_dato_out == CMD_CONT ? CONT :
                    uart.rx_dato_out == CMD_STEP ? STEP1 : IDLE;
`ifdef DEBUG_CTRL_ACK_EN
        if (uart.rx_done && state_d == IDLE) begin
          buf_d   = BUF_W'(8'h3F);
          cnt_d   = CNT_W'(1);
          state_d = SEND;
        end
`endif
      end
      CONT:  state_d = pc >= PC_W'(PC_STOP) ? LOAD : CONT;
      STEP1: state_d = STEP2;
      STEP2: state_d = LOAD;
      LOAD: begin
`ifdef DEBUG_CTRL_ACK_EN
        buf_d = {snap, 8'hA5};
`else
        buf_d = snap;
`endif
        cnt_d   = CNT_W'(NSEND);
        state_d = SEND;
      end
      SEND: begin
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (uart.tx_done) begin
          buf_d   = buf_q >> 8;
          state_d = |cnt_q ? SEND : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end
  assign enable          = state_q == CONT || state_q == STEP1;
  assign busy            = state_q != IDLE;
  assign uart.tx_start   = state_q == SEND;
  assign uart.tx_dato_in = buf_q[7:0];
endmodule

// File: tb/tb_debug_ctrl.sv
// tb_debug_ctrl: randomized bench with a byte-queue reference model of run/step/dump behaviour.
module tb_debug_ctrl;
  localparam int DATA_W  = 322;
  localparam int PC_W    = 10;
  localparam int PC_STOP = 62;
  localparam int NB      = (DATA_W + 7) / 8;
`ifdef DEBUG_CTRL_ACK_EN
  localparam int ACK = 1;
`else
  localparam int ACK = 0;
`endif
  localparam int NP = NB + ACK;
  logic clk = 0;
  logic rst = 1;
  logic [DATA_W-1:0] dbg;
  logic enable, busy;
  debug_ctrl_if u();
  debug_ctrl dut (.clk(clk), .reset(rst), .uart(u.master), .debug_signal(dbg), .enable(enable), .busy(busy));
  always #5 clk = ~clk;
  int errs = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      if (errs <= 40) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: command phases plus the queue of bytes still owed to the UART
  logic [7:0] q[$];
  bit m_run, m_busy, m_pulse, m_gap;
  int m_step, m_pre;
  logic [NB*8-1:0] pad;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete(); m_run = 0; m_busy = 0; m_pulse = 0; m_gap = 0; m_step = 0; m_pre = 0;
    end else if (m_pulse) begin
      m_pulse = 0; m_gap = 1;
    end else if (m_gap) begin
      if (u.tx_done) begin
        void'(q.pop_front());
        m_gap = 0;
        if (q.size() != 0) m_pulse = 1; else m_busy = 0;
      end
    end else if (m_run) begin
      if (dbg[DATA_W-1 -: PC_W] >= PC_STOP) begin m_run = 0; m_pre = 1; end
    end else if (m_step > 0) begin
      m_step--; m_pre = 2;
    end else if (m_pre > 0) begin
      if (m_pre == 1) begin
        pad = '0;
        pad[DATA_W-1:0] = dbg;
        q.delete();
        if (ACK != 0) q.push_back(8'hA5);
        for (int i = 0; i < NB; i++) q.push_back(pad[i*8 +: 8]);
        m_pulse = 1;
      end
      m_pre--;
    end else if (u.rx_done) begin
      if (u.rx_dato_out == 8'h63) begin m_busy = 1; m_run = 1; end
      else if (u.rx_dato_out == 8'h73) begin m_busy = 1; m_step = 1; end
      else if (ACK != 0) begin q.delete(); q.push_back(8'h3F); m_pulse = 1; m_busy = 1; end
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_enable", enable, 0);
      chk("rst_tx_start", u.tx_start, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_dato", u.tx_dato_in, 0);
    end else begin
      chk("enable", enable, m_run || m_step > 0);
      chk("busy", busy, m_busy);
      chk("tx_start", u.tx_start, m_pulse);
      if (m_pulse || m_gap) chk("tx_dato_in", u.tx_dato_in, q[0]);
    end
  end
  bit pend;
  int dly;
  initial begin
    u.tx_done = 0;
    pend = 0;
    forever begin
      @(negedge clk);
      u.tx_done = 0;
      if (pend) begin
        dly--;
        if (dly == 0) begin u.tx_done = 1; pend = 0; end
      end else if (u.tx_start) begin
        pend = 1; dly = $urandom_range(1, 4);
      end else u.tx_done = ($urandom % 10) == 0;
    end
  end
  logic [7:0] bytes[$];
  int en_cnt;
  bit prev_st;
  logic [PC_W-1:0] pc;
  task automatic rnd_dbg();
    for (int i = 0; i < DATA_W; i++) dbg[i] = 1'($urandom_range(0, 1));
  endtask
  task automatic cyc();
    @(negedge clk);
    if (enable) en_cnt++;
    if (u.tx_start) begin
      chk("tx_start_back_to_back", prev_st, 0);
      bytes.push_back(u.tx_dato_in);
    end
    prev_st = u.tx_start;
    if (enable && pc < PC_STOP) pc++;
    dbg[DATA_W-1 -: PC_W] = pc;
    if (busy && !enable && bytes.size() > 0)
      for (int k = 0; k < 4; k++) begin
        int b;
        b = $urandom_range(DATA_W - PC_W - 1, 0);
        dbg[b] = ~dbg[b];
      end
    u.rx_done = busy && ($urandom % 5) == 0;
    u.rx_dato_out = ($urandom % 2) != 0 ? 8'h73 : 8'h63;
  endtask
  task automatic cmd(input logic [7:0] b);
    cyc();
    bytes.delete();
    en_cnt = 0;
    u.rx_done = 1;
    u.rx_dato_out = b;
  endtask
  task automatic finish_dump();
    int n;
    n = 0;
    do begin cyc(); n++; end while (busy && n < 3000);
    chk("dump_timeout", busy, 0);
  endtask
  initial begin
    logic [7:0] c;
    int n;
    u.rx_done = 0;
    u.rx_dato_out = 0;
    pc = 0;
    prev_st = 0;
    rnd_dbg();
    repeat (3) @(negedge clk);
    chk("reset_enable", enable, 0);
    chk("reset_busy", busy, 0);
    chk("reset_tx_dato", u.tx_dato_in, 8'h00);
    #2 rst = 0;
    rnd_dbg();
    dbg[7:0] = 8'h12;
    pc = 5;
    cmd(8'h73);
    finish_dump();
    chk("step_pulses", bytes.size(), NP);
    chk("step_enable_cycles", en_cnt, 1);
    chk("step_byte0", bytes[ACK], 8'h12);
    chk("step_last_pad", bytes[NP-1] & 8'hC0, 8'h00);
    rnd_dbg();
    pc = 0;
    cmd(8'h63);
    finish_dump();
    chk("cont_pulses", bytes.size(), NP);
    chk("cont_enable_cycles", en_cnt, 62);
    chk("cont_pc_low", bytes[ACK+39], 8'h3E);
    chk("cont_pc_high", bytes[ACK+40], 8'h00);
    cmd(8'h78);
    finish_dump();
    chk("unknown_pulses", bytes.size(), ACK);
    chk("unknown_enable", en_cnt, 0);
    for (int t = 0; t < 25; t++) begin
      rnd_dbg();
      pc = PC_W'($urandom_range(40, 70));
      n = $urandom_range(0, 2);
      c = n == 0 ? 8'h63 : n == 1 ? 8'h73 : 8'($urandom);
      cmd(c);
      finish_dump();
      chk("rand_pulses", bytes.size(), (c == 8'h63 || c == 8'h73) ? NP : ACK);
    end
    rnd_dbg();
    cmd(8'h73);
    n = 0;
    do begin cyc(); n++; end while (bytes.size() < 5 && n < 1000);
    chk("reach_byte5", bytes.size(), 5);
    #2 rst = 1;
    #1;
    chk("async_rst_enable", enable, 0);
    chk("async_rst_tx_start", u.tx_start, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    #2 rst = 0;
    bytes.delete();
    en_cnt = 0;
    u.rx_done = 1;
    u.rx_dato_out = 8'h73;
    finish_dump();
    chk("post_rst_pulses", bytes.size(), NP);
    chk("post_rst_enable_cycles", en_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/debug_ctrl.md
DEBUG_CTRL -- requirements
Module: debug_ctrl

Interface
REQ-001 Parameter DATA_W, default 322: width of debug_signal snapshot in bits.
REQ-002 Parameter PC_W, default 10: width of PC field in debug_signal[DATA_W-1 -: PC_W].
REQ-003 Parameter PC_STOP, default 62: PC value at or above which a continue run ends.
REQ-004 Parameter CMD_CONT, default 8'h63 ("c"): continue command byte.
REQ-005 Parameter CMD_STEP, default 8'h73 ("s"): single-step command byte.
REQ-006 Local NUM_BYTES = ceil(DATA_W/8); 41 at default.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 rx_dato_out  input  8  byte from UART RX, valid when rx_done=1.
REQ-010 rx_done  input  1  one-cycle pulse, RX byte received.
REQ-011 tx_done  input  1  one-cycle pulse, TX finished current byte.
REQ-012 debug_signal  input  DATA_W  processor state vector.
REQ-013 enable  output  1  processor clock-enable.
REQ-014 tx_dato_in  output  8  byte to UART TX, stable from tx_start until tx_done.
REQ-015 tx_start  output  1  one-cycle pulse, start TX of tx_dato_in.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, CONT, STEP1, STEP2, LOAD, SEND, WAIT.
REQ-018 IDLE: rx_done=1 and byte=CMD_CONT -> CONT; byte=CMD_STEP -> STEP1; any other byte -> stay IDLE.
REQ-019 rx_done outside IDLE is ignored; no command queueing.
REQ-020 CONT: enable=1; when debug_signal PC field >= PC_STOP (unsigned), enable=0 next cycle and go to LOAD.
REQ-021 STEP1: enable=1 for exactly one cycle -> STEP2 (enable=0) -> LOAD.
REQ-022 LOAD: capture debug_signal into a NUM_BYTES*8-bit shift buffer, upper pad bits zero, byte counter=NUM_BYTES -> SEND.
REQ-023 SEND: tx_dato_in=buffer[7:0], tx_start=1 for one cycle, counter decremented -> WAIT.
REQ-024 WAIT: on tx_done, buffer shifted right 8; counter>0 -> SEND, counter=0 -> IDLE.
REQ-025 Bytes sent LSB-first; exactly NUM_BYTES tx_start pulses per dump; every DATA_W bit transmitted.
REQ-026 tx_start never asserted in consecutive cycles; minimum one WAIT cycle between pulses.
REQ-027 tx_done outside WAIT is ignored.
REQ-028 Snapshot is frozen at LOAD; debug_signal changes during SEND/WAIT do not affect transmitted bytes.
REQ-029 enable is 0 in IDLE, LOAD, SEND, WAIT.
REQ-030 Counter width = clog2(NUM_BYTES+1); no wrap.

Reset
REQ-031 reset=1 forces IDLE immediately, asynchronously, including mid-dump or mid-run.
REQ-032 Reset values: enable=0, tx_start=0, tx_dato_in=8'h00, busy=0, buffer=0, counter=0.
REQ-033 After reset deassertion, first rx_done is accepted on the next rising edge.

Configuration
REQ-034 Macro DEBUG_CTRL_ACK_EN defined: LOAD->SEND first transmits header 8'hA5, then NUM_BYTES snapshot bytes (NUM_BYTES+1 pulses); unknown command in IDLE sends one byte 8'h3F ("?") via SEND/WAIT, then IDLE.
REQ-035 Macro undefined: no header byte; unknown commands silently ignored; counter sized for NUM_BYTES.

Verification
REQ-036 reset mid-SEND at byte 5 -> same cycle enable=0, tx_start=0, busy=0; next "s" gives full 41-byte dump.
REQ-037 rx "s", debug_signal low byte 8'h12 -> enable high exactly 1 cycle; 41 tx_start pulses, first tx_dato_in=8'h12, last byte upper 6 bits zero.
REQ-038 rx "c", PC field ramps 0..62 -> enable high until PC=62, then low; 41-byte dump of state at PC=62.
REQ-039 rx "x" (8'h78) -> no tx_start, enable stays 0 (with DEBUG_CTRL_ACK_EN: single byte 8'h3F).
REQ-040 rx "s" during dump -> ignored; byte count stays 41; debug_signal toggled during dump -> transmitted bytes unchanged.
REQ-041 DEBUG_CTRL_ACK_EN defined, rx "s" -> 42 pulses, first byte 8'hA5.
